regfile_2r1w: RTL



---
 rtl/regfile_2r1w.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// Parametrised register file: one write port and two independent registered read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read.
`timescale 1ns/1ps
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] readnum_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b
);

  if (NREGS > (2 ** ADDR_W)) begin : g_bad_cfg
    $error("regfile_2r1w: NREGS exceeds address space");
  end

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  wr_en;
  logic [NREGS-1:0]  sel_a;
  logic [NREGS-1:0]  sel_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] data_a_p1;
  logic [DATA_W-1:0] data_b_p1;
  logic              vld_a_p1;
  logic              vld_b_p1;

  // Out-of-range addresses decode to an all-zero select, so they neither write nor read.
  always_comb begin
    wr_en = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_en[i] = write && !clear && (writenum == ADDR_W'(i));
      sel_a[i] = (readnum_a == ADDR_W'(i));
      sel_b[i] = (readnum_b == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) regs[i] <= data_in;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = |(wr_en & sel_a);
  assign fwd_b = |(wr_en & sel_b);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_a[i]) rdata_a = regs[i];
      if (sel_b[i]) rdata_b = regs[i];
    end
    if (fwd_a) rdata_a = data_in;
    if (fwd_b) rdata_b = data_in;
  end

  // ---- stage p1: registered read ports ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_p1 <= '0;
      vld_a_p1  <= 1'b0;
    end else begin
      vld_a_p1 <= rd_en_a;
      if (rd_en_a) data_a_p1 <= rdata_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_b_p1 <= '0;
      vld_b_p1  <= 1'b0;
    end else begin
      vld_b_p1 <= rd_en_b;
      if (rd_en_b) data_b_p1 <= rdata_b;
    end
  end

  assign data_out_a = data_a_p1;
  assign valid_a    = vld_a_p1;
  assign data_out_b = data_b_p1;
  assign valid_b    = vld_b_p1;

endmodule
